// File: rtl/gyrator_fixture_pkg.sv
// ---------------------------------------------------------------------------
// gyrator_fixture_pkg : shared types for the gyrator S-parameter fixture
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gyrator_fixture_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      MEAS   = 3'd2,
      NEXT   = 3'd3,
      DONE   = 3'd4
   } sweep_state_t;

   localparam logic PORT_P1 = 1'b0;
   localparam logic PORT_P2 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/gyrator_sweep_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer : loadable saturating down-counter with a zero flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module settle_timer #(
   parameter int SETTLE_W = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] value,
   output logic                zero
);

   logic [SETTLE_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (r_count != '0) begin
         r_count <= r_count - SETTLE_W'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/gyrator_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gyrator_sweep_ctrl : frequency/port sweep sequencer with capture handshake
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gyrator_sweep_ctrl
   import gyrator_fixture_pkg::*;
#(
   parameter int N_POINTS   = 16,
   parameter int IDX_W      = 4,
   parameter int SETTLE_W   = 12,
   parameter int SETTLE_CYC = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             meas_ack,
   output logic             busy,
   output logic             done,
   output logic             src_en,
   output logic             port_sel,
   output logic [IDX_W-1:0] freq_idx,
   output logic             meas_req
);

   localparam logic [SETTLE_W-1:0] C_RELOAD   = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0]    C_LAST_IDX = IDX_W'(N_POINTS - 1);

   sweep_state_t     r_state;
   sweep_state_t     w_state_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_port_nxt;
   logic             w_load;
   logic             w_zero;

   settle_timer #(
      .SETTLE_W (SETTLE_W)
   ) u_settle_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (w_load),
      .value (C_RELOAD),
      .zero  (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = freq_idx;
      w_port_nxt  = port_sel;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               w_state_nxt = SETTLE;
               w_idx_nxt   = '0;
               w_port_nxt  = PORT_P1;
               w_load      = 1'b1;
            end
         end
         SETTLE: begin
            if (w_zero) w_state_nxt = MEAS;
         end
         MEAS: begin
            if (meas_ack) w_state_nxt = NEXT;
         end
         NEXT: begin
            // Terminal index is tested before any increment, so freq_idx never wraps.
            if (port_sel == PORT_P1) begin
               w_port_nxt  = PORT_P2;
               w_load      = 1'b1;
               w_state_nxt = SETTLE;
            end else if (freq_idx == C_LAST_IDX) begin
               w_state_nxt = DONE;
               w_idx_nxt   = '0;
               w_port_nxt  = PORT_P1;
            end else begin
               w_port_nxt  = PORT_P1;
               w_idx_nxt   = freq_idx + IDX_W'(1);
               w_load      = 1'b1;
               w_state_nxt = SETTLE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (abort && (r_state != IDLE)) begin
         w_state_nxt = IDLE;
         w_idx_nxt   = '0;
         w_port_nxt  = PORT_P1;
         w_load      = 1'b0;
      end
   end

   // Outputs are decoded from the next state so every one of them is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         freq_idx <= '0;
         port_sel <= PORT_P1;
         busy     <= 1'b0;
         done     <= 1'b0;
         src_en   <= 1'b0;
         meas_req <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         freq_idx <= w_idx_nxt;
         port_sel <= w_port_nxt;
         busy     <= (w_state_nxt != IDLE);
         done     <= (w_state_nxt == DONE);
         src_en   <= (w_state_nxt == SETTLE) || (w_state_nxt == MEAS) || (w_state_nxt == NEXT);
         meas_req <= (w_state_nxt == MEAS);
      end
   end

endmodule

`default_nettype wire
